zapper_input: RTL
=================

// Module: zapper_input
// PURPOSE
//  Light-gun front end that feeds pattern_gen its trigger and detect inputs.
//  - Synchronises the raw gun trigger and photodiode pins and debounces the trigger.
//  - Qualifies the photodiode against the pixel stream.
//  - Latches a per-frame hit verdict, stable for one full frame.
//  - Sits between the board pins and the duck/flash pattern stage, in the pixel clock domain.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clk cycles trigger must stay changed before accepted (~10 ms @25.175 MHz)
//  DETECT_MIN_PIX   16      consecutive lit valid pixels needed to score a frame as a hit
//  SENSOR_ACT_LOW   1       1: sensor_raw low = light seen; 0: high = light seen
//  TRIG_ACT_LOW     0       1: trigger_raw low = pulled; 0: high = pulled
// PORTS
//  clk            in   1   pixel clock, single clock domain
//  rst_n          in   1   asynchronous active-low reset
//  trigger_raw    in   1   gun trigger pin, asynchronous
//  sensor_raw     in   1   gun photodiode pin, asynchronous
//  valid          in   1   high while the current pixel is in the visible area
//  frame_start    in   1   1-cycle pulse on the first clk of each frame
//  trigger        out  1   debounced trigger level, active high
//  trigger_pulse  out  1   1-cycle pulse on each accepted trigger press
//  detect         out  1   hit verdict of the most recently completed frame
//  light_pixels   out  19  count of lit valid pixels in the last completed frame
// BEHAVIOUR
//  Reset
//  - rst_n low asynchronously clears everything: synchronisers, debounce counter,
//    run counter, hit flag, accumulators and all outputs. All outputs read 0.
//  - Reset mid-frame discards the partial frame.
//  - The first frame_start after reset latches detect=0 unless a hit occurs in the
//    partial frame that follows reset.
//  Synchronise
//  - Each pin passes through a 2-flop synchroniser, then is polarity-normalised
//    to trig_s and sens_s (1 = active).
//  - Pin-to-internal latency is 2 clk.
//  Debounce FSM, states STABLE and COUNTING
//  - STABLE: trig_s == trigger; cnt = 0. On trig_s != trigger -> COUNTING, cnt = 1.
//  - COUNTING, trig_s back == trigger: -> STABLE, cnt = 0 (glitch rejected).
//  - COUNTING, cnt == DEBOUNCE_CYCLES-1 with trig_s still differing:
//    trigger <= ~trigger, go to STABLE, cnt = 0.
//  - Otherwise COUNTING: cnt++.
//  - Net effect: trigger flips exactly DEBOUNCE_CYCLES clk after trig_s first
//    differs, provided trig_s holds the whole time.
//  - trigger_pulse = 1 for the single clk in which trigger goes 0->1. No pulse on release.
//  - cnt width is $clog2(DEBOUNCE_CYCLES+1) and it never wraps.
//  Hit qualification
//  - Only cycles with valid=1 are counted. Cycles with valid=0 hold run and light accumulators.
//  - valid && sens_s: run <= min(run+1, DETECT_MIN_PIX); light_acc <= light_acc+1,
//    saturating at 2^19-1.
//  - valid && !sens_s: run <= 0.
//  - hit flag set on the cycle run reaches DETECT_MIN_PIX; it stays set until frame_start.
//  - A lit run is not broken by blanking, so runs span line ends.
//  Frame latch, on a frame_start cycle
//  - detect <= hit as of the previous cycle; light_pixels <= light_acc.
//  - Then hit, run and light_acc are cleared.
//  - The frame_start-cycle sample is counted into the new frame (the cleared
//    accumulator starts from that sample).
//  - detect and light_pixels change only on frame_start (or reset). They are
//    stable for a full frame, so the consumer may sample them on any edge of
//    its frame strobe.
//  - frame_start with valid=1 is legal; the sample belongs to the new frame.
//  Independence
//  - Debounce and hit paths are independent. A trigger flip and a frame_start
//    on the same cycle are both applied.
// TESTING (sim params: DEBOUNCE_CYCLES=8, DETECT_MIN_PIX=4, active-high pins)
//  1. trigger_raw 0->1 held 20 clk -> trigger rises exactly 10 clk after the pin
//     edge (2 sync + 8); trigger_pulse is high for 1 clk.
//  2. trigger_raw high for 5 clk then low -> trigger stays 0, no pulse.
//     Release after a press -> trigger falls 10 clk later, no pulse.
//  3. Frame with sensor lit for 4 consecutive valid pixels, then frame_start
//     -> detect=1, light_pixels=4.
//     Next frame dark -> detect=0 at the following frame_start.
//  4. Lit 3 valid pixels, 5 valid=0 cycles, lit 1 valid pixel, then frame_start
//     -> detect=1, light_pixels=4.
//     Repeat with a dark valid pixel in the gap -> detect=0.
//  5. rst_n pulsed low mid-frame after a hit -> all outputs 0 immediately.
//     Next frame_start -> detect=0.
//  6. frame_start coincident with a lit valid pixel -> old frame unaffected;
//     new frame's light count includes that pixel.

Source files
------------

// File: rtl/zapper_input.sv
// zapper_input: light-gun front end; synchronises and debounces the trigger,
// qualifies the photodiode against visible pixels and latches a per-frame hit verdict.
module zapper_input #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DETECT_MIN_PIX  = 16,
   parameter bit SENSOR_ACT_LOW  = 1'b1,
   parameter bit TRIG_ACT_LOW    = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger_raw,
   input  logic        sensor_raw,
   input  logic        valid,
   input  logic        frame_start,
   output logic        trigger,
   output logic        trigger_pulse,
   output logic        detect,
   output logic [18:0] light_pixels
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(DETECT_MIN_PIX + 1);
   localparam logic [0:0] STABLE   = 1'b0;
   localparam logic [0:0] COUNTING = 1'b1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RUN_MAX  = RW'(DETECT_MIN_PIX);
   logic [1:0]    trig_sync_q, sens_sync_q;
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          trigger_q, trigger_d, pulse_q, pulse_d;
   logic [RW-1:0] run_q, run_d, run_b;
   logic          hit_q, hit_d, hit_b;
   logic [18:0]   acc_q, acc_d, acc_b;
   logic          detect_q, detect_d;
   logic [18:0]   light_q, light_d;
   logic          trig_s, sens_s, differ, flip;
   always_comb begin
      trig_s    = trig_sync_q[1] ^ TRIG_ACT_LOW;
      sens_s    = sens_sync_q[1] ^ SENSOR_ACT_LOW;
      differ    = trig_s != trigger_q;
      flip      = state_q == COUNTING && differ && cnt_q == CNT_LAST;
      state_d   = (!differ || flip) ? STABLE : COUNTING;
      cnt_d     = state_d == STABLE ? '0 : cnt_q + 1'b1;
      trigger_d = trigger_q ^ flip;
      pulse_d   = flip && !trigger_q;
   end
   // A frame_start sample is accumulated on top of the freshly cleared frame state.
   always_comb begin
      run_b    = frame_start ? '0 : run_q;
      hit_b    = frame_start ? 1'b0 : hit_q;
      acc_b    = frame_start ? '0 : acc_q;
      run_d    = !valid ? run_b : !sens_s ? '0 : run_b == RUN_MAX ? RUN_MAX : run_b + 1'b1;
      acc_d    = (valid && sens_s && acc_b != '1) ? acc_b + 1'b1 : acc_b;
      hit_d    = hit_b || run_d == RUN_MAX;
      detect_d = frame_start ? hit_q : detect_q;
      light_d  = frame_start ? acc_q : light_q;
   end
   // Synchronisers reset to the idle pin level so reset never fakes a press or a lit pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_sync_q <= {2{TRIG_ACT_LOW}};
         sens_sync_q <= {2{SENSOR_ACT_LOW}};
         state_q     <= STABLE;
         cnt_q       <= '0;
         trigger_q   <= 1'b0;
         pulse_q     <= 1'b0;
         run_q       <= '0;
         hit_q       <= 1'b0;
         acc_q       <= '0;
         detect_q    <= 1'b0;
         light_q     <= '0;
      end else begin
         trig_sync_q <= {trig_sync_q[0], trigger_raw};
         sens_sync_q <= {sens_sync_q[0], sensor_raw};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         trigger_q   <= trigger_d;
         pulse_q     <= pulse_d;
         run_q       <= run_d;
         hit_q       <= hit_d;
         acc_q       <= acc_d;
         detect_q    <= detect_d;
         light_q     <= light_d;
      end
   end
   assign trigger       = trigger_q;
   assign trigger_pulse = pulse_q;
   assign detect        = detect_q;
   assign light_pixels  = light_q;
endmodule
